// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
//   Types and constants shared by the instruction-fetch controller.
//   Contents:
//     fetch_state_t  fetch sequencer states {IDLE, REQ, SKID}
//     INSTR_BYTES    bytes per instruction word (sequential PC step)
//     JIDX_W         width of the j-type target index field
//     next_pc()      sequential successor of a PC, 32-bit wrap
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SKID = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int JIDX_W      = 26;

    // 0xFFFF_FFFC rolls over to 0 by plain modulo arithmetic.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//   Request/ready bus between the fetch controller and instruction memory.
//   Signals:
//     imem_req    fetch request, held with a stable address until imem_ready
//     imem_addr   fetch byte address
//     imem_ready  imem_rdata valid; completes the request in this cycle
//     imem_rdata  fetched instruction word
//   Modports:
//     master  fetch controller side
//     slave   instruction memory side
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_target.sv
// -----------------------------------------------------------------------------
// fetch_target
//   Combinational redirect decision and target computation for decode-side
//   control transfers.
//   Ports:
//     stall        in   decode stalled; suppresses any redirect
//     jump         in   j-type instruction in decode (wins over beq)
//     branch       in   beq in decode
//     compare_zero in   beq operands equal
//     pc_hi        in   if_pc[31:28], region bits kept by a jump
//     pc_add_4     in   if_pc + 4, base of the beq offset
//     beq_ext_imm  in   sign-extended beq word offset
//     jump_idx     in   j-type target word index
//     redirect     out  take target this cycle
//     target       out  selected redirect byte address
// -----------------------------------------------------------------------------
module fetch_target
    import fetch_ctrl_pkg::*;
(
    input  logic                stall,
    input  logic                jump,
    input  logic                branch,
    input  logic                compare_zero,
    input  logic [3:0]          pc_hi,
    input  logic [31:0]         pc_add_4,
    input  logic signed [31:0]  beq_ext_imm,
    input  logic [JIDX_W-1:0]   jump_idx,
    output logic                redirect,
    output logic [31:0]         target
);
    logic [31:0] jump_target;
    logic [31:0] beq_target;

    assign jump_target = {pc_hi, jump_idx, 2'b00};
    // Word offset scaled to bytes; the sum wraps modulo 2^32.
    assign beq_target  = pc_add_4 + $unsigned(beq_ext_imm <<< 2);

    assign redirect = !stall && (jump || (branch && compare_zero));
    assign target   = jump ? jump_target : beq_target;
endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction fetch sequencer: owns the PC, issues req/ready fetches to
//   instruction memory, fills the IF/ID register and applies jump/beq
//   redirects coming back from decode.
//   Parameters:
//     RESET_PC  PC of the first fetch after reset
//     PERF_W    perf counter width (only with NPC_PERF_EN)
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     stall                    decode cannot accept IF/ID; hold if_* outputs
//     jump, branch             decode control-transfer indications
//     compare_zero             beq operands equal
//     beq_ext_imm              sign-extended beq word offset
//     jump_ins_add             jump instruction word, [25:0] = target index
//     imem                     fetch_ctrl_if.master request/ready bus
//     if_valid, if_pc,
//     if_pc_add_4, if_instr    IF/ID register towards decode
//     perf_fetch, perf_stall,
//     perf_redirect            event counters (only with NPC_PERF_EN)
//   Configuration macro:
//     NPC_PERF_EN  adds the PERF_W parameter and the three perf counters.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef NPC_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jump,
    input  logic               branch,
    input  logic               compare_zero,
    input  logic signed [31:0] beq_ext_imm,
    input  logic [31:0]        jump_ins_add,
    fetch_ctrl_if.master       imem,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_add_4,
    output logic [31:0]        if_instr
`ifdef NPC_PERF_EN
    ,
    output logic [PERF_W-1:0]  perf_fetch,
    output logic [PERF_W-1:0]  perf_stall,
    output logic [PERF_W-1:0]  perf_redirect
`endif
);
    fetch_state_t state, state_d;

    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        redirect;
    logic [31:0] target;
    logic        done;
    logic        take_mem;
    logic        take_skid;
    logic        skid_ld;

    // Upper opcode bits of the jump word carry no target information.
    logic        unused_jump_hi;
    assign unused_jump_hi = ^jump_ins_add[31:JIDX_W];

    assign if_pc_add_4 = next_pc(if_pc);

    fetch_target u_target (
        .stall        (stall),
        .jump         (jump),
        .branch       (branch),
        .compare_zero (compare_zero),
        .pc_hi        (if_pc[31:28]),
        .pc_add_4     (if_pc_add_4),
        .beq_ext_imm  (beq_ext_imm),
        .jump_idx     (jump_ins_add[JIDX_W-1:0]),
        .redirect     (redirect),
        .target       (target)
    );

    // Address stays at pc_q for the whole life of a request.
    assign imem.imem_req  = (state == REQ);
    assign imem.imem_addr = pc_q;
    assign done           = (state == REQ) && imem.imem_ready;

    always_comb begin
        state_d   = state;
        pc_d      = pc_q;
        kill_d    = kill_q;
        redir_d   = redir_q;
        take_mem  = 1'b0;
        take_skid = 1'b0;
        skid_ld   = 1'b0;

        case (state)
            IDLE: state_d = REQ;

            REQ: begin
                if (imem.imem_ready) begin
                    if (redirect) begin
                        // The word just returned is on the wrong path.
                        pc_d   = target;
                        kill_d = 1'b0;
                    end else if (kill_q) begin
                        // Request issued before an earlier redirect: drop it.
                        pc_d   = redir_q;
                        kill_d = 1'b0;
                    end else if (!stall) begin
                        take_mem = 1'b1;
                        pc_d     = next_pc(pc_q);
                    end else begin
                        // IF/ID is frozen: park the word so it is not lost.
                        skid_ld = 1'b1;
                        pc_d    = next_pc(pc_q);
                        state_d = SKID;
                    end
                end else if (redirect) begin
                    // Outstanding request cannot be aborted; mark it for discard.
                    kill_d  = 1'b1;
                    redir_d = target;
                end
            end

            SKID: begin
                if (!stall) begin
                    state_d = REQ;
                    if (redirect) begin
                        pc_d = target;
                    end else begin
                        take_skid = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ---- state / IF-ID register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else begin
            state  <= state_d;
            pc_q   <= pc_d;
            kill_q <= kill_d;
            if (take_mem) begin
                if_valid <= 1'b1;
                if_pc    <= pc_q;
                if_instr <= imem.imem_rdata;
            end else if (take_skid) begin
                if_valid <= 1'b1;
                if_pc    <= skid_pc;
                if_instr <= skid_instr;
            end else if (!stall) begin
                // Consumed with nothing new (or squashed by a redirect): bubble.
                if_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        redir_q <= redir_d;
        if (skid_ld) begin
            skid_instr <= imem.imem_rdata;
            skid_pc    <= pc_q;
        end
    end

`ifdef NPC_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch    <= '0;
            perf_stall    <= '0;
            perf_redirect <= '0;
        end else begin
            if (done && !redirect && !kill_q) perf_fetch <= perf_fetch + 1'b1;
            if (stall)                        perf_stall <= perf_stall + 1'b1;
            if (redirect)                     perf_redirect <= perf_redirect + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Scoreboard bench for fetch_ctrl. The driver decides stall/redirect each
//   cycle and, whenever decode consumes an instruction, pushes the PC that the
//   next consumed instruction must carry (program order with jump/beq applied).
//   A separate monitor pops and compares at every consumption and also checks
//   reset state and request stability on the imem bus.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic               jump;
    logic               branch;
    logic               compare_zero;
    logic signed [31:0] beq_ext_imm;
    logic [31:0]        jump_ins_add;
    logic               if_valid;
    logic [31:0]        if_pc;
    logic [31:0]        if_pc_add_4;
    logic [31:0]        if_instr;
`ifdef NPC_PERF_EN
    logic [31:0]        perf_fetch;
    logic [31:0]        perf_stall;
    logic [31:0]        perf_redirect;
`endif

    fetch_ctrl_if imem_bus();

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .jump         (jump),
        .branch       (branch),
        .compare_zero (compare_zero),
        .beq_ext_imm  (beq_ext_imm),
        .jump_ins_add (jump_ins_add),
        .imem         (imem_bus),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_pc_add_4  (if_pc_add_4),
        .if_instr     (if_instr)
`ifdef NPC_PERF_EN
        ,
        .perf_fetch   (perf_fetch),
        .perf_stall   (perf_stall),
        .perf_redirect(perf_redirect)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          consumed = 0;
    logic [31:0] exp_q[$];

    int p_ready    = 100;
    int p_stall    = 0;
    int p_redir    = 0;
    int fixed_wait = -1;
    int wait_cnt   = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        stall               = 1'b0;
        jump                = 1'b0;
        branch              = 1'b0;
        compare_zero        = 1'b0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = '0;
        wait_cnt            = 0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sets all inputs for the coming rising edge.
    task automatic drive_cycle();
        logic [31:0] cur;
        logic [31:0] nxt;
        logic [31:0] r;
        bit          rdy;
        int          kind;

        if (imem_bus.imem_req) begin
            if (fixed_wait >= 0) rdy = (wait_cnt >= fixed_wait);
            else                 rdy = ($urandom_range(99) < p_ready);
            if (rdy) wait_cnt = 0;
            else     wait_cnt++;
        end else begin
            rdy      = 1'b0;
            wait_cnt = 0;
        end
        imem_bus.imem_ready = rdy;
        imem_bus.imem_rdata = rdy ? mem_word(imem_bus.imem_addr) : $urandom;

        stall        = ($urandom_range(99) < p_stall);
        r            = $urandom;
        beq_ext_imm  = {{16{r[15]}}, r[15:0]};
        jump_ins_add = $urandom;
        compare_zero = 1'($urandom_range(1));
        jump         = 1'b0;
        branch       = 1'b0;

        if (stall) begin
            // Control-transfer requests under stall must be ignored.
            jump   = ($urandom_range(3) == 0);
            branch = ($urandom_range(3) == 0);
        end else if (if_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty_drive: actual 0 entries required 1 (t=%0t)", $time);
            end else begin
                cur = exp_q[0];
                nxt = cur + 32'd4;
                if ($urandom_range(99) < p_redir) begin
                    kind = $urandom_range(4);
                    case (kind)
                        0: jump = 1'b1;
                        1: begin branch = 1'b1; compare_zero = 1'b1; end
                        2: begin branch = 1'b1; compare_zero = 1'b0; end
                        3: begin jump = 1'b1; branch = 1'b1; compare_zero = 1'b1; end
                        default: begin
                            // Land on 0xFFFF_FFF8 so sequential fetch wraps to 0.
                            branch       = 1'b1;
                            compare_zero = 1'b1;
                            beq_ext_imm  = $signed((32'hFFFF_FFF8 - cur - 32'd4) >> 2);
                        end
                    endcase
                    if (jump)
                        nxt = {cur[31:28], jump_ins_add[25:0], 2'b00};
                    else if (branch && compare_zero)
                        nxt = cur + 32'd4 + ($unsigned(beq_ext_imm) << 2);
                end
                exp_q.push_back(nxt);
            end
        end
    endtask

    // Monitor: samples 2 time units after the falling edge.
    initial begin
        logic        rst_prev;
        logic        wait_prev;
        logic [31:0] addr_prev;
        logic [31:0] e;
        int          idle;
        rst_prev  = 1'b0;
        wait_prev = 1'b0;
        addr_prev = '0;
        idle      = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_prev) begin
                check("rst_if_valid", 32'(if_valid), 32'd0);
                check("rst_if_pc", if_pc, 32'd0);
                check("rst_if_instr", if_instr, 32'd0);
                check("rst_imem_req", 32'(imem_bus.imem_req), 32'd0);
            end else if (wait_prev) begin
                check("req_hold", 32'(imem_bus.imem_req), 32'd1);
                check("addr_hold", imem_bus.imem_addr, addr_prev);
            end

            if (!rst && if_valid && !stall) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: actual if_pc %h required no instruction (t=%0t)",
                             if_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e);
                    check("if_pc_add_4", if_pc_add_4, e + 32'd4);
                    check("if_instr", if_instr, mem_word(e));
                    consumed++;
                end
            end else begin
                idle++;
                if (idle > 200) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL progress: actual %0d idle cycles required <= 200 (t=%0t)", idle, $time);
                    idle = 0;
                end
            end

            wait_prev = !rst && imem_bus.imem_req && !imem_bus.imem_ready;
            addr_prev = imem_bus.imem_addr;
            rst_prev  = rst;
        end
    end

    initial begin
        int reqs_seen;
        int cfg[4][3];
        rst                 = 1'b1;
        stall               = 1'b0;
        jump                = 1'b0;
        branch              = 1'b0;
        compare_zero        = 1'b0;
        beq_ext_imm         = '0;
        jump_ins_add        = '0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = '0;
        cfg = '{'{100, 30, 20}, '{40, 40, 25}, '{70, 10, 40}, '{30, 50, 30}};

        @(negedge clk);
        do_reset();

        // Zero-wait memory, no stall: sequential addresses from RESET_PC.
        reqs_seen = 0;
        p_ready = 100; p_stall = 0; p_redir = 0; fixed_wait = -1;
        for (int c = 0; c < 12; c++) begin
            if (imem_bus.imem_req && reqs_seen < 3) begin
                check("zero_wait_addr", imem_bus.imem_addr, RESET_PC + 32'(4 * reqs_seen));
                reqs_seen++;
            end
            drive_cycle();
            @(negedge clk);
        end
        check("zero_wait_req_count", 32'(reqs_seen), 32'd3);

        // Three wait states per request.
        do_reset();
        fixed_wait = 3;
        for (int c = 0; c < 40; c++) begin
            drive_cycle();
            @(negedge clk);
        end
        fixed_wait = -1;

        // Randomised traffic with occasional mid-flight resets.
        for (int k = 0; k < 4; k++) begin
            p_ready = cfg[k][0];
            p_stall = cfg[k][1];
            p_redir = cfg[k][2];
            for (int c = 0; c < 800; c++) begin
                if ($urandom_range(249) == 0) do_reset();
                drive_cycle();
                @(negedge clk);
            end
        end

        check("consumed_enough", 32'(consumed >= 300), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
